alu_addand_unit: RTL and testbench
==================================

// Module: alu_addand_unit
// PURPOSE
//   Registered ALU slice for the 20-bit CPU datapath. Implements three ops:
//   add-without-carry (ADD), add-with-carry (ADC) and bitwise AND. Each op runs
//   in full-word (20-bit) or half-word (low 10-bit) mode. Results go to the
//   register-file write path; the zero and carry flags go to the status register.
// PARAMETERS
//   WORD_W   20   full-word datapath width
//   HALF_W   10   half-word width; uses bits [HALF_W-1:0]
// PORTS
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        launch the op this cycle
//   op         in   2        00=ADD, 01=ADC, 10=AND, 11=reserved
//   mode       in   1        1=full-word, 0=half-word
//   a          in   WORD_W   operand A
//   b          in   WORD_W   operand B
//   out_valid  out  1        c/zero reflect an op launched last cycle
//   c          out  WORD_W   result
//   zero       out  1        result == 0 over the active width
//   carry      out  1        carry flag; also the ADC carry-in
// BEHAVIOUR
//   - All outputs are registered. Latency is 1 cycle: in_valid at edge N gives
//     out_valid=1 and the result after edge N+1. No stall or backpressure.
//   - Reset: rst_n=0 at a clock edge sets c=0, zero=0, carry=0 and out_valid=0.
//     Reset overrides any in_valid in the same cycle, and an op in flight is dropped.
//   - Active width is W = mode ? WORD_W : HALF_W. In half-word mode:
//     * bits [WORD_W-1:HALF_W] of a and b are ignored;
//     * c[WORD_W-1:HALF_W] is driven to 0.
//   - ADD: c[W-1:0] = a + b (mod 2^W). Carry-in is ignored.
//     carry <= carry-out of bit W-1. zero <= (c[W-1:0] == 0).
//   - ADC: c[W-1:0] = a + b + carry (mod 2^W). The carry-in is the flag value
//     before this edge. carry <= carry-out of bit W-1. zero updates as for ADD.
//   - AND: c[W-1:0] = a & b. zero updates. carry holds its value.
//   - op=11 with in_valid=1: nothing updates and out_valid=0.
//   - in_valid=0: c, zero and carry hold their values and out_valid=0.
//   - Back-to-back ADC ops chain the carry correctly, one op per cycle.
//   - All arithmetic is unsigned modulo 2^W. No overflow or sign flags.
// STRUCTURE
//   - Shared package alu_pkg holds:
//     * localparams WORD_W=20 and HALF_W=10;
//     * op encodings OP_ADD, OP_ADC, OP_AND, OP_RSVD.
//     Other ALU classes (shift, compare) reuse the same package.
//   - One combinational sub-module, alu_adder_core, computes
//     (a, b, cin, mode) -> (sum[WORD_W-1:0], cout). It masks the upper bits in
//     half-word mode and takes cout from bit HALF_W-1 or WORD_W-1.
//   - The top level holds the op mux, the zero reduction and the output/flag
//     registers.
// TESTING
//   1. Reset: hold rst_n=0 with in_valid=1, op=ADD, a=b=0xFFFFF
//      -> c=0x00000, zero=0, carry=0, out_valid=0.
//   2. Full-word ADD: mode=1, a=0x7FFFF, b=0x00001
//      -> c=0x80000, zero=0, carry=0, out_valid=1 one cycle later.
//   3. Carry chain, mode=1:
//      - ADD a=0xFFFFF, b=0x00001 -> c=0x00000, zero=1, carry=1;
//      - then ADC a=0x00010, b=0x00020 -> c=0x00031, carry=0;
//      - then ADD 1+1 with carry preset to 1 -> c=0x00002 (carry-in ignored).
//   4. Half-word ADD: mode=0, a=0xFFFFF, b=0x00001
//      -> c=0x00000, zero=1, carry=1. Also a=0xAB001, b=0x54002
//      -> c=0x00003, zero=0, carry=0 (upper bits ignored).
//   5. AND: mode=1, a=0xF0F0F, b=0x0FF00 -> c=0x00F00, zero=0.
//      Then mode=0, a=0xFFC00, b=0xFFFFF -> c=0x00000, zero=1.
//      carry is unchanged by both.
//   6. Idle/reserved: in_valid=0, or op=11 with in_valid=1
//      -> c, zero and carry hold their previous values, out_valid=0.
//      Also assert rst_n=0 mid-stream -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : widths, op encodings and helpers shared by the ALU classes     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int WORD_W = 20;
  localparam int HALF_W = 10;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADC  = 2'b01,
    OP_AND  = 2'b10,
    OP_RSVD = 2'b11
  } alu_op_e;

  typedef logic [WORD_W-1:0] word_t;

  // Keeps only the bits that belong to the active width of the given mode.
  function automatic word_t width_mask(input logic full_mode);
    word_t m;
    m = '0;
    m[HALF_W-1:0] = '1;
    if (full_mode) m = '1;
    return m;
  endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_adder_core.sv
// +--------------------------------------------------------------------------+
// | alu_adder_core : combinational width-selectable adder with carry in/out  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_adder_core
  import alu_pkg::*;
(
  input  logic              mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] a_act;
  logic [WORD_W-1:0] b_act;
  logic [WORD_W:0]   raw;

  assign mask  = width_mask(mode);
  assign a_act = a & mask;
  assign b_act = b & mask;
  assign raw   = {1'b0, a_act} + {1'b0, b_act} + {{WORD_W{1'b0}}, cin};

  // Half-word carry lands in bit HALF_W because the upper operand bits are zero.
  assign sum  = raw[WORD_W-1:0] & mask;
  assign cout = mode ? raw[WORD_W] : raw[HALF_W];

endmodule : alu_adder_core

`default_nettype wire

// File: rtl/alu_addand_unit.sv
// +--------------------------------------------------------------------------+
// | alu_addand_unit : registered ADD / ADC / AND slice with zero+carry flags |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_addand_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic              mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  output logic [WORD_W-1:0] c,
  output logic              zero,
  output logic              carry
);

  alu_op_e           op_sel;
  logic              launch;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic [WORD_W-1:0] and_res;
  logic [WORD_W-1:0] result;
  logic              result_zero;
  logic              carry_next;

  assign op_sel = alu_op_e'(op);
  assign launch = in_valid && (op_sel != OP_RSVD);

  // ADC consumes the flag as it stood before this edge, which chains back-to-back ops.
  assign add_cin = (op_sel == OP_ADC) ? carry : 1'b0;

  alu_adder_core u_adder (
    .mode (mode),
    .a    (a),
    .b    (b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign and_res = a & b & width_mask(mode);

  always_comb begin
    result     = add_sum;
    carry_next = add_cout;
    if (op_sel == OP_AND) begin
      result     = and_res;
      carry_next = carry;
    end
  end

  // Upper bits are already zero in half-word mode, so a full-width test suffices.
  assign result_zero = (result == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else begin
      out_valid <= launch;
      if (launch) begin
        c     <= result;
        zero  <= result_zero;
        carry <= carry_next;
      end
    end
  end

endmodule : alu_addand_unit

`default_nettype wire

// File: tb/tb_alu_addand_unit.sv
// +--------------------------------------------------------------------------+
// | tb_alu_addand_unit : directed + random checks against an arithmetic model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_addand_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  op;
  logic        mode;
  logic [19:0] a;
  logic [19:0] b;
  logic        out_valid;
  logic [19:0] c;
  logic        zero;
  logic        carry;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference state: what the outputs must show after the next edge.
  logic [19:0] m_c;
  logic        m_zero;
  logic        m_carry;
  logic        m_valid;

  always #5 clk = ~clk;

  alu_addand_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c),
    .zero      (zero),
    .carry     (carry)
  );

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_asserts++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".c"},         c,                 m_c);
    chk({tag, ".zero"},      {19'd0, zero},     {19'd0, m_zero});
    chk({tag, ".carry"},     {19'd0, carry},    {19'd0, m_carry});
    chk({tag, ".out_valid"}, {19'd0, out_valid}, {19'd0, m_valid});
  endtask

  // Drive one cycle, advance the model by the op's arithmetic meaning, sample after the edge.
  task automatic step(input logic v, input logic [1:0] o, input logic md,
                      input logic [19:0] x, input logic [19:0] y);
    longint unsigned modulus, ax, bx, s;
    int w;
    in_valid = v; op = o; mode = md; a = x; b = y;
    if (v && o != 2'b11) begin
      w       = md ? 20 : 10;
      modulus = 64'd1 << w;
      ax      = longint'(x) % modulus;
      bx      = longint'(y) % modulus;
      if (o == 2'b10) begin
        s   = ax & bx;
        m_c = 20'(s);
      end else begin
        s       = ax + bx + ((o == 2'b01) ? longint'(m_carry) : 64'd0);
        m_c     = 20'(s % modulus);
        m_carry = (s >= modulus);
      end
      m_zero  = (m_c == 20'd0);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; op = 2'b00; mode = 1'b1; a = 20'hFFFFF; b = 20'hFFFFF;
    m_c = '0; m_zero = 1'b0; m_carry = 1'b0; m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    do_reset();
    chk_model("reset");
    chk("reset.c_const", c, 20'h00000);
    rst_n = 1'b1;

    step(1, 2'b00, 1, 20'h7FFFF, 20'h00001);
    chk_model("add_full");
    chk("add_full.c_const", c, 20'h80000);

    step(1, 2'b00, 1, 20'hFFFFF, 20'h00001);
    chk_model("add_wrap");
    chk("add_wrap.carry_const", {19'd0, carry}, 20'd1);
    step(1, 2'b01, 1, 20'h00010, 20'h00020);
    chk_model("adc_chain");
    chk("adc_chain.c_const", c, 20'h00031);
    step(1, 2'b00, 1, 20'hFFFFF, 20'h00001);
    step(1, 2'b00, 1, 20'h00001, 20'h00001);
    chk_model("add_ignores_cin");
    chk("add_ignores_cin.c_const", c, 20'h00002);

    step(1, 2'b00, 0, 20'hFFFFF, 20'h00001);
    chk_model("add_half_wrap");
    chk("add_half_wrap.c_const", c, 20'h00000);
    step(1, 2'b00, 0, 20'hAB001, 20'h54002);
    chk_model("add_half_upper");
    chk("add_half_upper.c_const", c, 20'h00003);

    // Set carry first so the AND steps prove it is held.
    step(1, 2'b00, 0, 20'h003FF, 20'h00001);
    step(1, 2'b01, 0, 20'h00200, 20'h00100);
    chk_model("adc_half_cin");
    chk("adc_half_cin.c_const", c, 20'h00301);
    step(1, 2'b00, 0, 20'h003FF, 20'h00001);
    step(1, 2'b10, 1, 20'hF0F0F, 20'h0FF00);
    chk_model("and_full");
    chk("and_full.c_const", c, 20'h00F00);
    step(1, 2'b10, 0, 20'hFFC00, 20'hFFFFF);
    chk_model("and_half");
    chk("and_half.carry_const", {19'd0, carry}, 20'd1);

    step(1, 2'b00, 1, 20'h12345, 20'h00001);
    step(0, 2'b00, 1, 20'h00001, 20'h00001);
    chk_model("idle");
    step(1, 2'b11, 1, 20'h00001, 20'h00001);
    chk_model("reserved");
    chk("reserved.c_const", c, 20'h12346);

    do_reset();
    chk_model("mid_reset");
    rst_n = 1'b1;
    step(1, 2'b01, 1, 20'h00001, 20'h00002);
    chk_model("post_reset_adc");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        chk_model("rand_reset");
        rst_n = 1'b1;
      end else begin
        step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             20'($urandom), 20'($urandom));
        chk_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule : tb_alu_addand_unit

`default_nettype wire
